rv32m_muldiv_unit: RTL and testbench
====================================

Name: rv32m_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit in the EX stage, beside the single-cycle ALU.
- Consumes the decoded func3 of an OP instruction with funct7 = 0000001 and two operands.
- Produces the 32-bit result over multiple cycles and holds a busy flag that the hazard unit uses to stall IF/ID/EX.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- func3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val  input  XLEN  operand A (multiplicand/dividend)
- rs2_val  input  XLEN  operand B (multiplier/divisor)
- flush  input  1  pipeline flush; aborts any operation
- busy  output  1  high while an accepted operation is in progress (CALC, FIX)
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  result; held stable from done until the next accepted start

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; busy = 0, done = 0, result = 0; all internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- Start acceptance:
  - IDLE with start = 1 latches func3 and the operands.
  - If the operation needs sign handling, operand magnitudes are stored and the result-sign flag is recorded.
  - Transition to CALC, with the iteration counter at XLEN-1.
- Fast paths: IDLE -> DONE directly, so done rises on the cycle after the start edge.
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give rs1_val.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, multiply: shift-add on a 2*XLEN accumulator, one multiplier bit per cycle, XLEN cycles.
- CALC, divide: restoring division, one quotient bit per cycle, XLEN cycles, using an (XLEN+1)-bit partial remainder.
- CALC exit: the counter decrements each cycle; at 0 go to FIX.
- FIX (1 cycle) applies sign correction:
  - MUL/MULH: negate the 64-bit product if exactly one operand was negative.
  - MULHSU: only rs1 is treated as signed.
  - DIV: quotient negative iff the operand signs differ.
  - REM: remainder takes the sign of the dividend.
- FIX then selects the output: low word for MUL, high word for MULH/MULHSU/MULHU, quotient or remainder for divides. Result is registered, then go to DONE.
- DONE (1 cycle): done = 1, busy = 0, then return to IDLE.
- Normal latency: the start edge is cycle 0; busy is high in cycles 1..XLEN+1 (CALC + FIX); done is high in cycle XLEN+2, i.e. 34 for XLEN = 32.
- Start outside IDLE: ignored, with no queuing. The stall guarantees this; an assertion is also required.
- Start in DONE: ignored; it is re-presented the next cycle.
- Flush: synchronous, highest priority over all else. Any state goes to IDLE next cycle; done is suppressed; result keeps its previous value. flush with start in IDLE: start is dropped.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
- Arithmetic:
  - All internal widths are explicit; no truncation until the final select.
  - Negation is two's complement within the declared width.
  - 0x80000000 magnitude is represented correctly in unsigned form.

Decomposition:
- defines.v additions:
  - func3 constants `MD_MUL..`MD_REMU.
  - State encodings `MD_IDLE, `MD_CALC, `MD_FIX, `MD_DONE.
- One sub-module is natural: rv32m_sign_fix, combinational magnitude/negate helpers used at entry and in FIX.
- The FSM, counter and datapath live in rv32m_muldiv_unit.

Test Plan:
- MUL 7 * -3 (rs1 = 0x7, rs2 = 0xFFFFFFFD) -> done at cycle 34, result 0xFFFFFFEB; busy high cycles 1..33.
- MULH / MULHSU / MULHU with rs1 = rs2 = 0x80000000:
  - MULH -> 0x40000000
  - MULHSU -> 0xC0000000
  - MULHU -> 0x40000000
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU -> 1.
- DIV / REM fast paths:
  - Divide 5 by 0: DIV -> 0xFFFFFFFF, REMU -> 5, with done on cycle 1.
  - DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0, with done on cycle 1.
- Flush at cycle 10 of a DIV -> IDLE at cycle 11; no done pulse; result unchanged. A start at cycle 12 is accepted normally.
- rst low at cycle 15 of a MUL -> busy/done/result immediately 0. A second start asserted at cycle 5 of a MUL is ignored; only one done pulse occurs.

Source files
------------

// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit: operation codes,
// FSM states and per-operation operand signedness.
package rv32m_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic rs1_is_signed(md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic rs2_is_signed(md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface rv32m_muldiv_unit_if #(parameter int XLEN = 32);

    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, rs1_val, rs2_val, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, func3, rs1_val, rs2_val, flush,
        output busy, done, result
    );

endinterface

// File: rtl/rv32m_sign_fix.sv
// Combinational sign helpers: operand magnitudes at entry and conditional
// two's-complement negation of the double-width raw result.
module rv32m_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic              a_signed_i,
    input  logic              b_signed_i,
    output logic [XLEN-1:0]   a_mag_o,
    output logic [XLEN-1:0]   b_mag_o,
    output logic              a_neg_o,
    output logic              b_neg_o,
    input  logic [2*XLEN-1:0] val_i,
    input  logic              neg_i,
    output logic [2*XLEN-1:0] val_o
);

    // Negating 0x80000000 yields 0x80000000, which read unsigned is 2^31.
    assign a_neg_o = a_signed_i & a_i[XLEN-1];
    assign b_neg_o = b_signed_i & b_i[XLEN-1];
    assign a_mag_o = a_neg_o ? (~a_i) + XLEN'(1) : a_i;
    assign b_mag_o = b_neg_o ? (~b_i) + XLEN'(1) : b_i;
    assign val_o   = neg_i ? (~val_i) + (2*XLEN)'(1) : val_i;

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide, one
// bit per cycle, with a one-cycle sign fix-up and single-cycle fast paths.
module rv32m_muldiv_unit
    import rv32m_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    rv32m_muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    md_op_e            op_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              a_neg, b_neg;
    logic [2*XLEN-1:0] fix_val, fix_out;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_trial;

    assign op_in = md_op_e'(bus.func3);

    rv32m_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .a_i        (bus.rs1_val),
        .b_i        (bus.rs2_val),
        .a_signed_i (rs1_is_signed(op_in)),
        .b_signed_i (rs2_is_signed(op_in)),
        .a_mag_o    (a_mag),
        .b_mag_o    (b_mag),
        .a_neg_o    (a_neg),
        .b_neg_o    (b_neg),
        .val_i      (fix_val),
        .neg_i      (neg_q),
        .val_o      (fix_out)
    );

    assign div_zero = (bus.rs2_val == '0);
    assign div_ovf  = (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1)
                      && (op_in == MD_DIV || op_in == MD_REM);

    // Multiply: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

    // Divide: dividend bits shift out of acc_q MSB first, quotient bits shift in.
    assign div_shift = {rem_q, acc_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, opb_q};

    always_comb begin
        fix_val = acc_q;
        if (op_q == MD_REM || op_q == MD_REMU) begin
            fix_val = {{XLEN{1'b0}}, rem_q};
        end else if (op_q == MD_DIV || op_q == MD_DIVU) begin
            fix_val = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        result_d = result_q;
        if (bus.flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (bus.start) begin
                        op_d = op_in;
                        if (bus.func3[2] && div_zero) begin
                            result_d = bus.func3[1] ? bus.rs1_val : '1;
                            state_d  = MD_DONE;
                        end else if (div_ovf) begin
                            result_d = bus.func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                            state_d  = MD_DONE;
                        end else begin
                            neg_d   = (op_in == MD_REM) ? a_neg : (a_neg ^ b_neg);
                            acc_d   = {{XLEN{1'b0}}, bus.func3[2] ? a_mag : b_mag};
                            opb_d   = bus.func3[2] ? b_mag : a_mag;
                            rem_d   = '0;
                            cnt_d   = CW'(XLEN - 1);
                            state_d = MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (op_q[2]) begin
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN]};
                        rem_d = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
                    end else begin
                        acc_d = mul_next;
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = MD_FIX;
                    end
                end
                MD_FIX: begin
                    result_d = (op_q == MD_MUL || op_q[2]) ? fix_out[XLEN-1:0]
                                                          : fix_out[2*XLEN-1:XLEN];
                    state_d  = MD_DONE;
                end
                MD_DONE: begin
                    state_d = MD_IDLE;
                end
                default: begin
                    state_d = MD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == MD_CALC) || (state_q == MD_FIX);
    assign bus.done   = (state_q == MD_DONE) && !bus.flush;
    assign bus.result = result_q;

    // The hazard unit stalls the issuing stage, so a start while busy is dropped.
    a_no_start_when_busy : assert property (@(posedge clk) disable iff (!rst)
        !(bus.start && bus.busy))
        else $warning("start asserted while busy; request ignored");

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed self-checking bench for rv32m_muldiv_unit.
module tb_rv32m_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rv32m_muldiv_unit_if #(.XLEN(32)) bus_if ();

    rv32m_muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request during the current cycle; returns at the negedge of cycle 1.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus_if.func3   = f;
        bus_if.rs1_val = a;
        bus_if.rs2_val = b;
        bus_if.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.start   = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int inj, input int post);
        int lat      = 0;
        int busy_bad = 0;
        int extra    = 0;
        bus_if.func3   = f;
        bus_if.rs1_val = a;
        bus_if.rs2_val = b;
        bus_if.start   = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 1) bus_if.start = 1'b0;
            if (inj != 0 && k == inj) begin
                bus_if.start   = 1'b1;
                bus_if.func3   = 3'd4;
                bus_if.rs1_val = 32'd1;
                bus_if.rs2_val = 32'd0;
            end
            if (inj != 0 && k == inj + 1) bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) begin
                if (bus_if.busy !== 1'b0) busy_bad++;
                lat = k;
                break;
            end
            if (bus_if.busy !== 1'b1) busy_bad++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, bus_if.result, exp);
        chk({tag, "_busy"}, busy_bad, 0);
        for (int j = 0; j < post; j++) begin
            @(negedge clk);
            if (bus_if.done !== 1'b0) extra++;
            if (bus_if.busy !== 1'b0) extra++;
            if (bus_if.result !== exp) extra++;
        end
        chk({tag, "_after_done"}, extra, 0);
    endtask

    initial begin
        bus_if.start   = 1'b0;
        bus_if.flush   = 1'b0;
        bus_if.func3   = 3'd0;
        bus_if.rs1_val = 32'd0;
        bus_if.rs2_val = 32'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_busy", bus_if.busy, 0);
        chk("reset_done", bus_if.done, 0);
        chk("reset_result", bus_if.result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("mul_7x-3", 3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, 2);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 1);
        run_op("mulhsu_min", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34, 0, 1);
        run_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, 1);
        run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 1);
        run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, 1);
        run_op("divu_max_2", 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 0, 1);
        run_op("remu_max_2", 3'd7, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34, 0, 1);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34, 0, 1);
        run_op("rem_7_-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0, 1);

        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 2);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 2);
        run_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 2);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1, 0, 2);

        // Flush in cycle 10 of a divide.
        start_op(3'd4, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus_if.flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", bus_if.busy, 0);
        chk("flush_done", bus_if.done, 0);
        chk("flush_result_held", bus_if.result, 32'd5);
        bus_if.flush = 1'b0;
        run_op("div_after_flush", 3'd4, 32'd100, 32'd7, 32'd14, 34, 0, 2);

        // Flush together with start in IDLE drops the request.
        bus_if.func3   = 3'd4;
        bus_if.rs1_val = 32'd5;
        bus_if.rs2_val = 32'd0;
        bus_if.start   = 1'b1;
        bus_if.flush   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.flush = 1'b0;
        chk("flush_start_busy", bus_if.busy, 0);
        chk("flush_start_done", bus_if.done, 0);
        chk("flush_start_result", bus_if.result, 32'd14);

        // Second start in cycle 5 is ignored; exactly one done pulse.
        run_op("mul_second_start", 3'd0, 32'h10, 32'h3, 32'h30, 34, 5, 12);

        // Asynchronous reset in cycle 15 of a multiply.
        start_op(3'd0, 32'h1234, 32'h5678);
        repeat (14) @(negedge clk);
        chk("mid_busy_before_rst", bus_if.busy, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", bus_if.busy, 0);
        chk("rst_mid_done", bus_if.done, 0);
        chk("rst_mid_result", bus_if.result, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", bus_if.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
